id_operand_stage: RTL and testbench

- Decode-side operand fetch stage, directly upstream of reg_file's read ports and downstream of instruction decode.
- Drives the register-file read addresses and consumes the combinational read data.
- Bypasses in-flight results from the MEM and WB stages and detects RAW hazards that cannot be bypassed, then stalls.
- Registers the resolved operands into the ID/EX pipeline register, with a valid/ready handshake on both sides.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/operand_fwd_mux.sv | 32 +++
 rtl/id_operand_stage.sv | 102 ++++++++++
 tb/tb_id_operand_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, register-index constants and control-bundle field offsets.
//   XLEN    - datapath width
//   CTRL_W  - width of the opaque decoded control bundle
//   REG_X0  - hard-wired zero register index
//   CTRL_*  - field offsets/widths inside the control bundle (interpreted by EX)
package riscv_pkg;
   localparam int XLEN = 32;
   localparam int CTRL_W = 16;
   localparam logic [4:0] REG_X0 = 5'd0;
   localparam int CTRL_ALU_OP_LSB = 0;
   localparam int CTRL_ALU_OP_W = 4;
   localparam int CTRL_USE_IMM_BIT = 4;
   localparam int CTRL_REG_WE_BIT = 5;
   localparam int CTRL_MEM_WE_BIT = 6;
   localparam int CTRL_BRANCH_BIT = 7;
   localparam int CTRL_JUMP_BIT = 8;
   localparam int CTRL_MEM_SIZE_LSB = 9;
   localparam int CTRL_MEM_SIZE_W = 2;
   localparam int CTRL_MEM_UNSIGNED_BIT = 11;
endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: resolves one source operand from x0, MEM bypass, WB bypass or register file.
//   idx                       - source register index
//   rf_data                   - register-file read data for idx
//   mem_we/mem_wa/mem_wd      - MEM-stage pending write
//   mem_is_load               - MEM-stage result is a load (data not yet available)
//   wb_we/wb_wa/wb_wd         - WB-stage write, same cycle as the reg_file write
//   operand                   - resolved operand value
module operand_fwd_mux
   import riscv_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic [4:0]   idx,
   input  logic [W-1:0] rf_data,
   input  logic         mem_we,
   input  logic [4:0]   mem_wa,
   input  logic [W-1:0] mem_wd,
   input  logic         mem_is_load,
   input  logic         wb_we,
   input  logic [4:0]   wb_wa,
   input  logic [W-1:0] wb_wd,
   output logic [W-1:0] operand
);
   logic nz, mem_hit, wb_hit;
   // idx != x0 also blocks forwarding of writes addressed to x0
   assign nz = idx != REG_X0;
   assign mem_hit = nz && mem_we && mem_wa == idx && !mem_is_load;
   // WB write lands in reg_file only at the edge, so bypass it this cycle
   assign wb_hit = nz && wb_we && wb_wa == idx;
   always_comb
      operand = !nz ? '0 : mem_hit ? mem_wd : wb_hit ? wb_wd : rf_data;
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: operand fetch with MEM/WB bypass, RAW hazard stall and ID/EX register.
//   clk, rst (async, active-high), flush (squash ID/EX and incoming beat)
//   in_*            - decoded instruction with valid/ready handshake
//   rf_ra*/rf_rd*   - register-file read ports
//   mem_*/wb_*      - in-flight results for bypass/hazard detection
//   out_*           - registered ID/EX payload with valid/ready handshake
//   stall_cnt       - saturating count of hazard-stall cycles
module id_operand_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter int CTRL_W = riscv_pkg::CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [4:0]        in_rd,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              in_mem_rd,
   output logic [4:0]        rf_ra1,
   output logic [4:0]        rf_ra2,
   input  logic [XLEN-1:0]   rf_rd1,
   input  logic [XLEN-1:0]   rf_rd2,
   input  logic              mem_we,
   input  logic [4:0]        mem_wa,
   input  logic [XLEN-1:0]   mem_wd,
   input  logic              mem_is_load,
   input  logic              wb_we,
   input  logic [4:0]        wb_wa,
   input  logic [XLEN-1:0]   wb_wd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_op1,
   output logic [XLEN-1:0]   out_op2,
   output logic [XLEN-1:0]   out_imm,
   output logic [4:0]        out_rd,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              out_mem_rd,
   output logic [31:0]       stall_cnt
);
   logic [XLEN-1:0] op1, op2;
   logic            hz1, hz2, hazard, adv, take;
   assign rf_ra1 = in_rs1;
   assign rf_ra2 = in_rs2;
   operand_fwd_mux #(.W(XLEN)) u_fwd1 (
      .idx(in_rs1), .rf_data(rf_rd1),
      .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_is_load(mem_is_load),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .operand(op1)
   );
   operand_fwd_mux #(.W(XLEN)) u_fwd2 (
      .idx(in_rs2), .rf_data(rf_rd2),
      .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_is_load(mem_is_load),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .operand(op2)
   );
   // Unbypassable: producer still in EX, or a load whose data is not back until WB
   assign hz1 = in_rs1 != REG_X0 &&
                ((out_valid && out_rd == in_rs1) || (mem_we && mem_is_load && mem_wa == in_rs1));
   assign hz2 = in_rs2 != REG_X0 &&
                ((out_valid && out_rd == in_rs2) || (mem_we && mem_is_load && mem_wa == in_rs2));
   assign hazard = in_valid && (hz1 || hz2);
   assign adv = !out_valid || out_ready;
   assign take = adv && in_valid && !hazard;
   assign in_ready = adv && !hazard && !flush;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_pc     <= '0;
         out_op1    <= '0;
         out_op2    <= '0;
         out_imm    <= '0;
         out_rd     <= '0;
         out_ctrl   <= '0;
         out_mem_rd <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (adv) begin
         out_valid <= take;
         if (take) begin
            out_pc     <= in_pc;
            out_op1    <= op1;
            out_op2    <= op2;
            out_imm    <= in_imm;
            out_rd     <= in_rd;
            out_ctrl   <= in_ctrl;
            out_mem_rd <= in_mem_rd;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (hazard && !flush && stall_cnt != 32'hFFFF_FFFF)
         stall_cnt <= stall_cnt + 32'd1;
   end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed plus randomized scoreboard bench for id_operand_stage.
module tb_id_operand_stage;
   logic        clk = 1'b0, rst = 1'b1, flush, in_valid, in_ready, in_mem_rd;
   logic [31:0] in_pc, in_imm, rf_rd1, rf_rd2, mem_wd, wb_wd;
   logic [4:0]  in_rs1, in_rs2, in_rd, rf_ra1, rf_ra2, mem_wa, wb_wa;
   logic [15:0] in_ctrl;
   logic        mem_we, mem_is_load, wb_we, out_valid, out_ready, out_mem_rd;
   logic [31:0] out_pc, out_op1, out_op2, out_imm, stall_cnt;
   logic [4:0]  out_rd;
   logic [15:0] out_ctrl;
   typedef struct packed {
      logic [31:0] pc, op1, op2, imm;
      logic [4:0]  rd;
      logic [15:0] ctrl;
      logic        mrd;
   } beat_t;
   beat_t       q[$];
   int          n_vec = 0, n_bad = 0;
   logic        m_valid = 1'b0, drop;
   logic [4:0]  m_rd = '0;
   logic [31:0] m_cnt = '0;

   always #5 clk = ~clk;

   id_operand_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
      .in_ctrl(in_ctrl), .in_mem_rd(in_mem_rd), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
      .mem_is_load(mem_is_load), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op1(out_op1),
      .out_op2(out_op2), .out_imm(out_imm), .out_rd(out_rd), .out_ctrl(out_ctrl),
      .out_mem_rd(out_mem_rd), .stall_cnt(stall_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   // Architectural value a source should see: x0 is zero, youngest available producer wins
   function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] rfd);
      if (idx == 0) return 32'd0;
      if (mem_we && !mem_is_load && mem_wa == idx) return mem_wd;
      if (wb_we && wb_wa == idx) return wb_wd;
      return rfd;
   endfunction

   // A source must wait if its producer sits in ID/EX or is a load still in MEM
   function automatic logic must_wait(input logic [4:0] idx);
      return idx != 0 && ((m_valid && m_rd == idx) || (mem_we && mem_is_load && mem_wa == idx));
   endfunction

   task automatic idle();
      flush = 0; in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_imm = 0;
      in_ctrl = 0; in_mem_rd = 0; rf_rd1 = 0; rf_rd2 = 0; mem_we = 0; mem_wa = 0; mem_wd = 0;
      mem_is_load = 0; wb_we = 0; wb_wa = 0; wb_wd = 0; out_ready = 1;
   endtask

   task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic ld);
      in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_mem_rd = ld;
      in_pc = in_pc + 4; in_imm = $urandom; in_ctrl = 16'($urandom);
   endtask

   // Check the stage-level outputs for the current inputs, then advance the reference model
   task automatic cycle();
      logic hz, adv;
      @(negedge clk);
      hz = in_valid && (must_wait(in_rs1) || must_wait(in_rs2));
      adv = !m_valid || out_ready;
      chk("in_ready", 32'(in_ready), 32'(adv && !hz && !flush));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("stall_cnt", stall_cnt, m_cnt);
      chk("rf_ra1", 32'(rf_ra1), 32'(in_rs1));
      chk("rf_ra2", 32'(rf_ra2), 32'(in_rs2));
      if (hz && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      drop = flush;
      if (flush) m_valid = 0;
      else if (adv) begin
         if (in_valid && !hz) begin
            q.push_back('{in_pc, ref_operand(in_rs1, rf_rd1), ref_operand(in_rs2, rf_rd2),
                          in_imm, in_rd, in_ctrl, in_mem_rd});
            m_rd = in_rd;
         end
         m_valid = in_valid && !hz;
      end
      @(posedge clk);
      if (drop) q.delete();
      #1;
   endtask

   // Monitor: whenever the DUT presents a beat it must match the oldest expected one
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_beat at %0t: got out_pc %h, expected no valid beat", $time, out_pc);
         end else begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_op1", out_op1, q[0].op1);
            chk("out_op2", out_op2, q[0].op2);
            chk("out_imm", out_imm, q[0].imm);
            chk("out_rd", 32'(out_rd), 32'(q[0].rd));
            chk("out_ctrl", 32'(out_ctrl), 32'(q[0].ctrl));
            chk("out_mem_rd", 32'(out_mem_rd), 32'(q[0].mrd));
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      idle();
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_op1", out_op1, 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      #11 rst = 0;
      @(posedge clk); #1;
      // ADD x3 = x1 + x2 from the register file
      instr(1, 2, 3, 0); rf_rd1 = 5; rf_rd2 = 7; cycle();
      idle(); cycle();
      // x0 source ignores a MEM write addressed to x0
      instr(0, 0, 4, 0); mem_we = 1; mem_wa = 0; mem_wd = 32'hDEAD; cycle();
      idle(); cycle();
      // ALU producer: one bubble, then forward from MEM
      instr(1, 2, 5, 0); cycle();
      instr(5, 0, 7, 0); rf_rd1 = 32'h9999; cycle();
      mem_we = 1; mem_wa = 5; mem_wd = 32'h10; cycle();
      idle(); cycle();
      // Load producer: two bubbles, then forward from WB over a stale rf value
      instr(1, 1, 6, 1); cycle();
      instr(0, 6, 8, 0); rf_rd2 = 32'h1111; cycle();
      mem_we = 1; mem_is_load = 1; mem_wa = 6; cycle();
      mem_we = 0; mem_is_load = 0; wb_we = 1; wb_wa = 6; wb_wd = 32'hABCD; cycle();
      idle(); cycle();
      // Backpressure holds the payload, then flush squashes it
      instr(1, 2, 9, 0); rf_rd1 = 3; cycle();
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin instr(3, 4, 10, 0); cycle(); end
      flush = 1; cycle();
      idle(); cycle();
      // Async reset while stalled, then a clean acceptance
      out_ready = 0; instr(1, 2, 5, 0); cycle();
      instr(5, 0, 11, 0); cycle();
      #1 rst = 1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_stall_cnt", stall_cnt, 32'd0);
      rst = 0;
      m_valid = 0; m_cnt = 0; q.delete();
      out_ready = 1; cycle();
      idle(); cycle();
      // Randomized traffic on a small register window to provoke hazards and bypasses
      for (int i = 0; i < 800; i++) begin
         in_valid = $urandom_range(0, 9) < 8;
         in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
         in_rd = 5'($urandom_range(0, 7)); in_mem_rd = 1'($urandom);
         in_pc = $urandom; in_imm = $urandom; in_ctrl = 16'($urandom);
         rf_rd1 = $urandom; rf_rd2 = $urandom;
         mem_we = 1'($urandom); mem_wa = 5'($urandom_range(0, 7)); mem_wd = $urandom;
         mem_is_load = 1'($urandom);
         wb_we = 1'($urandom); wb_wa = 5'($urandom_range(0, 7)); wb_wd = $urandom;
         out_ready = $urandom_range(0, 3) != 0;
         flush = $urandom_range(0, 19) == 0;
         cycle();
      end
      idle();
      for (int i = 0; i < 3; i++) cycle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
